fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch front-end for the ARM single-cycle core: it produces the `Instr` word and PC that the controller and datapath consume, and takes `PCSrc` plus the branch target back from them. It keeps the PC and issues word reads to instruction memory over a request/acknowledge handshake. Fetched words go into a small prefetch FIFO. A taken branch flushes the FIFO, drops any in-flight response and refetches from the target.

## Interface
- `RESET_PC`, default 32'h0000_0000: address of the first fetch after reset.
- `DEPTH`, default 2: prefetch FIFO entries; must be a power of two and at least 2.
- `clk` in, 1: single clock; all state updates on the rising edge.
- `reset` in, 1: asynchronous, active-low reset (asserted when 0).
- `imem_req` out, 1: read request to instruction memory.
- `imem_addr` out, 32: word-aligned read address; bits [1:0] are always 0.
- `imem_ack` in, 1: read data valid this cycle, completing the outstanding request.
- `imem_rdata` in, 32: instruction word, sampled when `imem_ack`=1.
- `instr_valid` out, 1: the FIFO head holds a valid instruction.
- `Instr` out, 32: instruction at the FIFO head.
- `pc_out` out, 32: address of the instruction at the FIFO head.
- `instr_ready` in, 1: the consumer takes the head this cycle.
- `PCSrc` in, 1: redirect request (taken branch or PC write).
- `branch_target` in, 32: redirect address, sampled when `PCSrc`=1; bits [1:0] are ignored and forced to 0.

## Operation
- **State machine.** States are `S_REQ`, `S_WAIT` and `S_DROP`.
  - `S_REQ`: asserts `imem_req` with `imem_addr` = `fetch_pc` when the slot is free, i.e. `count` + outstanding < `DEPTH`; otherwise stays idle in `S_REQ`. When the request is issued, go to `S_WAIT`.
  - `S_WAIT`: holds `imem_req`=1 with a stable address until `imem_ack`.
    - On ack, push `{fetch_pc, imem_rdata}` and set `fetch_pc` += 4.
    - If space remains after that push (counting a same-cycle pop), stay in `S_WAIT` and issue the next address the following cycle.
    - Otherwise go to `S_REQ`.
  - `S_DROP`: a request was in flight when a redirect arrived. Hold the request until `imem_ack`, discard the data, then go to `S_REQ` using the latched target.
- **FIFO.** `DEPTH` entries of {pc[31:0], instr[31:0]}.
  - Push on an accepted ack; pop when `instr_valid` & `instr_ready`.
  - A simultaneous push and pop leaves `count` unchanged.
  - Pointers wrap modulo `DEPTH`.
  - `count` uses $clog2(`DEPTH`)+1 bits.
- **Redirect.** When `PCSrc`=1, the redirect has priority over push and pop in the same cycle:
  - FIFO cleared (`count`=0, pointers reset);
  - `fetch_pc` set to `branch_target` & ~3;
  - any ack in that cycle is discarded;
  - if in `S_WAIT` without an ack, go to `S_DROP`; otherwise go to `S_REQ`.
  - A second redirect while in `S_DROP` only updates `fetch_pc`; the state stays `S_DROP`.
- **Address arithmetic.** `fetch_pc` is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0 silently.
- **Reset.** A mid-operation reset discards the outstanding request; memory must tolerate an abandoned request.
- **Reset values.**
  - `imem_req`=0, `imem_addr`=`RESET_PC`;
  - `instr_valid`=0, `Instr`=0, `pc_out`=0;
  - state `S_REQ`, `count`=0, `fetch_pc`=`RESET_PC`;
  - performance counters (see Configuration) = 0.

## Timing
- First request: `imem_req`=1 with `imem_addr`=`RESET_PC` in the first cycle after `reset` deasserts.
- Latency: an ack in cycle N gives `instr_valid`=1 in cycle N+1, with `Instr`/`pc_out` registered from the FIFO head.
- Throughput: one instruction per cycle when memory acks in the same cycle as the request and the consumer pops every cycle.
- `Instr` and `pc_out` are stable while `instr_valid`=1 and `instr_ready`=0.
- A redirect in cycle N gives `instr_valid`=0 in cycle N+1. If nothing was in flight, the target request is issued in cycle N+1.

## Configuration
- Macro `FETCH_PERF_EN`.
- Defined: adds output ports `perf_fetched` [15:0] and `perf_flushed` [15:0]. Both are saturating counters of accepted pushes and of redirect cycles respectively, reset to 0.
- Undefined: neither the ports nor the counters exist; function is otherwise identical.

## Structure
- Package `fetch_pkg`: state enum `fetch_state_t` (`S_REQ`, `S_WAIT`, `S_DROP`), `fifo_entry_t` struct {pc, instr}, constant `INSTR_BYTES`=4.
- One sub-module, `fetch_fifo`: a parameterised synchronous FIFO with flush, push, pop, count and head outputs. The top-level holds the FSM and the PC.

## Test plan
- **Reset and fill.** Release reset with `RESET_PC`=0x100 and memory acking 1 cycle after each request; hold `instr_ready`=0.
  - Expect requests to 0x100 and 0x104, then `imem_req`=0 with `count`=2.
  - Expect the head to show `pc_out`=0x100.
- **Streaming.** Memory acks in the same cycle and `instr_ready`=1 continuously.
  - Expect `pc_out` to step 0x0, 0x4, 0x8, … one per cycle.
- **Redirect, idle memory.** `PCSrc`=1 with `branch_target`=0x2003 while the FIFO is full.
  - Next cycle: `instr_valid`=0 and `imem_addr`=0x2000.
  - The first instruction delivered has `pc_out`=0x2000.
- **Redirect in flight.** Redirect to 0x400 in `S_WAIT` with the ack 3 cycles later carrying 0xDEAD_BEEF.
  - That data is never presented on `Instr`.
  - The next request goes to 0x400.
- **Simultaneous events.**
  - Redirect, ack and pop all in one cycle: the FIFO is empty next cycle and the acked word is dropped.
  - Address wrap: a fetch at 0xFFFF_FFFC is followed by a request to 0x0.
- **Reset mid-fetch.** Assert `reset`=0 while `imem_req`=1.
  - All outputs return to their reset values immediately.
  - With `FETCH_PERF_EN` defined, both counters read 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch front-end: FSM states, prefetch entry layout.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fifo_entry_t;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries with synchronous flush; flush beats push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  fifo_entry_t              wdata,
  output fifo_entry_t              head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  fifo_entry_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is cleared on reset so the head reads zero until the first push.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: PC, request/ack memory FSM and prefetch FIFO with redirect flush.
// Optional `FETCH_PERF_EN adds saturating fetched/flushed counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] Instr,
  output logic [31:0] pc_out,
  input  logic        instr_ready,
  input  logic        PCSrc,
  input  logic [31:0] branch_target
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] perf_fetched,
  output logic [15:0] perf_flushed
`endif
);

  localparam int          CW       = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [31:0] START_PC = align_word(RESET_PC);

  fetch_state_t  state;
  fetch_state_t  state_nxt;
  logic [31:0]   fetch_pc;
  logic [31:0]   fetch_pc_nxt;
  logic [31:0]   drop_addr;
  logic          fetch_en;

  logic [CW-1:0] count;
  logic          fifo_empty;
  fifo_entry_t   head;
  fifo_entry_t   push_entry;

  logic          pop_fire;
  logic          req_issue;
  logic          accept;
  logic [CW:0]   fill_after;
  logic          room_after;

  // fetch_en holds off the first request until the first edge after reset release.
  assign pop_fire   = instr_valid && instr_ready;
  assign req_issue  = fetch_en && (state == S_REQ) && (count < DEPTH_C) && !PCSrc;
  assign imem_req   = req_issue || (state == S_WAIT) || (state == S_DROP);
  assign imem_addr  = (state == S_DROP) ? drop_addr : fetch_pc;
  assign accept     = imem_ack && !PCSrc && (req_issue || (state == S_WAIT));
  assign fill_after = {1'b0, count} + {{CW{1'b0}}, 1'b1} - {{CW{1'b0}}, pop_fire};
  assign room_after = fill_after < {1'b0, DEPTH_C};

  assign push_entry.pc    = fetch_pc;
  assign push_entry.instr = imem_rdata;

  assign instr_valid = !fifo_empty;
  assign Instr       = head.instr;
  assign pc_out      = head.pc;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (PCSrc),
    .push  (accept),
    .pop   (pop_fire),
    .wdata (push_entry),
    .head  (head),
    .count (count),
    .empty (fifo_empty)
  );

  // A redirect overrides everything; an in-flight request without its ack must drain in S_DROP.
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    if (PCSrc) begin
      fetch_pc_nxt = align_word(branch_target);
      case (state)
        S_WAIT:  state_nxt = imem_ack ? S_REQ : S_DROP;
        S_DROP:  state_nxt = imem_ack ? S_REQ : S_DROP;
        default: state_nxt = S_REQ;
      endcase
    end else begin
      case (state)
        S_REQ, S_WAIT: begin
          if (accept) begin
            fetch_pc_nxt = fetch_pc + INSTR_BYTES;
            state_nxt    = room_after ? S_WAIT : S_REQ;
          end else if (req_issue) begin
            state_nxt = S_WAIT;
          end
        end
        S_DROP: begin
          if (imem_ack) begin
            state_nxt = S_REQ;
          end
        end
        default: state_nxt = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_REQ;
      fetch_pc  <= START_PC;
      drop_addr <= START_PC;
      fetch_en  <= 1'b0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      fetch_en <= 1'b1;
      if ((state == S_WAIT) && (state_nxt == S_DROP)) begin
        drop_addr <= fetch_pc;
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (accept && (perf_fetched != 16'hFFFF)) begin
        perf_fetched <= perf_fetched + 16'd1;
      end
      if (PCSrc && (perf_flushed != 16'hFFFF)) begin
        perf_flushed <= perf_flushed + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table for fill/redirect, hand sequences for the rest.
module tb_fetch_unit;

  typedef struct {
    logic        ready;
    logic        pcsrc;
    logic [31:0] target;
    logic        expReq;
    logic [31:0] expAddr;
    logic        expValid;
    logic [31:0] expPc;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] Instr;
  logic [31:0] pc_out;
  logic        instr_ready;
  logic        PCSrc;
  logic [31:0] branch_target;
`ifdef FETCH_PERF_EN
  logic [15:0] perfFetched;
  logic [15:0] perfFlushed;
`endif

  int          checks;
  int          failures;
  int          ackMode;
  logic        pend;
  logic        manAck;
  logic [31:0] manData;
  vec_t        vecs [15];

  fetch_unit #(
    .RESET_PC (32'h0000_0100),
    .DEPTH    (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .Instr         (Instr),
    .pc_out        (pc_out),
    .instr_ready   (instr_ready),
    .PCSrc         (PCSrc),
    .branch_target (branch_target)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched  (perfFetched),
    .perf_flushed  (perfFlushed)
`endif
  );

  function automatic logic [31:0] instrOf(input logic [31:0] addr);
    return addr ^ 32'hE1A0_0000;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: mode 0 acks in the request cycle, mode 1 one cycle later, mode 2 manual.
  always @(posedge clk or negedge reset) begin
    if (!reset) pend <= 1'b0;
    else        pend <= (ackMode == 1) && imem_req && !imem_ack;
  end

  assign imem_ack   = (ackMode == 0) ? imem_req :
                      (ackMode == 1) ? (imem_req && pend) : manAck;
  assign imem_rdata = (ackMode == 2) ? manData : instrOf(imem_addr);

  task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string tag, input logic expReq, input logic [31:0] expAddr,
                             input logic expValid, input logic [31:0] expPc);
    checkVal({tag, " imem_req"}, {31'b0, imem_req}, {31'b0, expReq});
    checkVal({tag, " imem_addr"}, imem_addr, expAddr);
    checkVal({tag, " instr_valid"}, {31'b0, instr_valid}, {31'b0, expValid});
    if (expValid) begin
      checkVal({tag, " pc_out"}, pc_out, expPc);
      checkVal({tag, " Instr"}, Instr, instrOf(expPc));
    end
  endtask

  task automatic applyStimulus(input logic ready, input logic pcsrc, input logic [31:0] target,
                               input logic ack, input logic [31:0] data);
    @(posedge clk);
    #1;
    instr_ready   = ready;
    PCSrc         = pcsrc;
    branch_target = target;
    manAck        = ack;
    manData       = data;
    @(negedge clk);
  endtask

  task automatic doReset(input int mode);
    ackMode       = mode;
    reset         = 1'b0;
    instr_ready   = 1'b0;
    PCSrc         = 1'b0;
    branch_target = '0;
    manAck        = 1'b0;
    manData       = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    checks   = 0;
    failures = 0;

    vecs[0]  = '{1'b0, 1'b0, 32'h0,    1'b1, 32'h100,  1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,    1'b1, 32'h100,  1'b0, 32'h0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,    1'b1, 32'h104,  1'b1, 32'h100};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,    1'b1, 32'h104,  1'b1, 32'h100};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,    1'b0, 32'h108,  1'b1, 32'h100};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,    1'b0, 32'h108,  1'b1, 32'h100};
    vecs[6]  = '{1'b1, 1'b0, 32'h0,    1'b1, 32'h108,  1'b1, 32'h104};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,    1'b1, 32'h108,  1'b0, 32'h0};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,    1'b1, 32'h10C,  1'b1, 32'h108};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,    1'b1, 32'h10C,  1'b1, 32'h108};
    vecs[10] = '{1'b0, 1'b0, 32'h0,    1'b0, 32'h110,  1'b1, 32'h108};
    vecs[11] = '{1'b0, 1'b1, 32'h2003, 1'b0, 32'h110,  1'b1, 32'h108};
    vecs[12] = '{1'b0, 1'b0, 32'h0,    1'b1, 32'h2000, 1'b0, 32'h0};
    vecs[13] = '{1'b0, 1'b0, 32'h0,    1'b1, 32'h2000, 1'b0, 32'h0};
    vecs[14] = '{1'b0, 1'b0, 32'h0,    1'b1, 32'h2004, 1'b1, 32'h2000};

    // Reset values, then fill with a one-cycle-late memory and redirect while full.
    ackMode       = 1;
    reset         = 1'b0;
    instr_ready   = 1'b0;
    PCSrc         = 1'b0;
    branch_target = '0;
    manAck        = 1'b0;
    manData       = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkVal("reset imem_req", {31'b0, imem_req}, 32'h0);
    checkVal("reset imem_addr", imem_addr, 32'h100);
    checkVal("reset instr_valid", {31'b0, instr_valid}, 32'h0);
    checkVal("reset Instr", Instr, 32'h0);
    checkVal("reset pc_out", pc_out, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].ready, vecs[i].pcsrc, vecs[i].target, 1'b0, 32'h0);
      checkOutput($sformatf("vec%0d", i), vecs[i].expReq, vecs[i].expAddr,
                  vecs[i].expValid, vecs[i].expPc);
    end

    // Redirect while in flight, a second redirect during drain, late ack carrying junk.
    doReset(2);
    applyStimulus(1'b0, 1'b0, 32'h0,   1'b0, 32'h0);
    checkOutput("drop c1", 1'b1, 32'h100, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h400, 1'b0, 32'h0);
    checkOutput("drop c2", 1'b1, 32'h100, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h600, 1'b0, 32'h0);
    checkOutput("drop c3", 1'b1, 32'h100, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h400, 1'b0, 32'h0);
    checkOutput("drop c4", 1'b1, 32'h100, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0,   1'b1, 32'hDEAD_BEEF);
    checkOutput("drop c5", 1'b1, 32'h100, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0,   1'b0, 32'h0);
    checkOutput("drop c6", 1'b1, 32'h400, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0,   1'b1, instrOf(32'h400));
    checkOutput("drop c7", 1'b1, 32'h400, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0,   1'b0, 32'h0);
    checkOutput("drop c8", 1'b1, 32'h404, 1'b1, 32'h400);
`ifdef FETCH_PERF_EN
    checkVal("perf fetched after drop", {16'b0, perfFetched}, 32'd1);
    checkVal("perf flushed after drop", {16'b0, perfFlushed}, 32'd3);
`endif

    // Redirect + ack + pop in one cycle, then streaming and the address wrap.
    doReset(0);
    applyStimulus(1'b0, 1'b0, 32'h0,    1'b0, 32'h0);
    checkOutput("simul c1", 1'b1, 32'h100, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h3000, 1'b0, 32'h0);
    checkOutput("simul c2", 1'b1, 32'h104, 1'b1, 32'h100);
    applyStimulus(1'b0, 1'b0, 32'h0,    1'b0, 32'h0);
    checkOutput("simul c3", 1'b1, 32'h3000, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h0,    1'b0, 32'h0);
    checkOutput("simul c4", 1'b1, 32'h3004, 1'b1, 32'h3000);
    applyStimulus(1'b1, 1'b0, 32'h0,    1'b0, 32'h0);
    checkOutput("stream start", 1'b1, 32'h0, 1'b0, 32'h0);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput($sformatf("stream %0d", k), 1'b1, 32'(4 * k + 4), 1'b1, 32'(4 * k));
    end
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0);
    checkOutput("wrap redirect", 1'b1, 32'h1C, 1'b1, 32'h18);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("wrap c1", 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("wrap c2", 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFF8);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("wrap c3", 1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("wrap c4", 1'b1, 32'h4, 1'b1, 32'h0);

    // Reset asserted mid-fetch with a valid head and a live request.
    doReset(0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("midrst c1", 1'b1, 32'h100, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("midrst c2", 1'b1, 32'h104, 1'b1, 32'h100);
`ifdef FETCH_PERF_EN
    checkVal("perf fetched before reset", {16'b0, perfFetched}, 32'd1);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checkVal("midrst imem_req", {31'b0, imem_req}, 32'h0);
    checkVal("midrst imem_addr", imem_addr, 32'h100);
    checkVal("midrst instr_valid", {31'b0, instr_valid}, 32'h0);
    checkVal("midrst Instr", Instr, 32'h0);
    checkVal("midrst pc_out", pc_out, 32'h0);
`ifdef FETCH_PERF_EN
    checkVal("midrst perf_fetched", {16'b0, perfFetched}, 32'h0);
    checkVal("midrst perf_flushed", {16'b0, perfFlushed}, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
